// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory-side responder sequencing fetch/load/commit for the cpu
//
// Purpose: serves instruction fetch at pc and data load/store at addr from one
// single-port 16-bit word array, stepping each instruction through
// FETCH -> LOAD -> COMMIT and strobing step once per instruction.
//
// Optional feature macro: MEM_RESP_MMIO_EN
//   When defined, address 16'hFFFF is a 16-bit io register exposed on io_out.
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-high reset
//   pc           in   16  instruction word address
//   addr         in   16  data word address
//   wdata        in   16  store data
//   write        in   1   store request, acted on in COMMIT
//   instruction  out  16  registered instruction word
//   data         out  16  registered load data
//   step         out  1   one-cycle commit strobe (high during COMMIT)
//   io_out       out  16  io register (MEM_RESP_MMIO_EN only)
//   fault        out  1   sticky out-of-range access flag
module mem_responder #(
  parameter int AW = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        write,
  output logic [15:0] instruction,
  output logic [15:0] data,
  output logic        step,
`ifdef MEM_RESP_MMIO_EN
  output logic [15:0] io_out,
`endif
  output logic        fault
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] mem [DEPTH];

  logic        pc_ok;
  logic        addr_ok;
  logic        addr_io;
  logic        store_en;
  logic [15:0] io_rd;

  // An address is in range when every bit above the array index is zero.
  assign pc_ok   = (pc[15:AW] == '0);
  assign addr_ok = (addr[15:AW] == '0);

`ifdef MEM_RESP_MMIO_EN
  assign addr_io = (addr == IO_ADDR);
  assign io_rd   = io_out;
`else
  assign addr_io = 1'b0;
  assign io_rd   = 16'h0000;
`endif

  // Reset forces state to FETCH asynchronously, so an abandoned COMMIT can
  // never reach the array.
  assign store_en = (state == COMMIT) && write && addr_ok;

  // Array has no reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (store_en) begin
      mem[addr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      instruction <= 16'h0000;
      data        <= 16'h0000;
      step        <= 1'b0;
      fault       <= 1'b0;
`ifdef MEM_RESP_MMIO_EN
      io_out      <= 16'h0000;
`endif
    end else begin
      step <= 1'b0;
      case (state)
        FETCH: begin
          // The io register is never fetchable; FFFF is out of range here.
          instruction <= pc_ok ? mem[pc[AW-1:0]] : 16'h0000;
          if (!pc_ok) begin
            fault <= 1'b1;
          end
          state <= LOAD;
        end
        LOAD: begin
          if (addr_io) begin
            data <= io_rd;
          end else if (addr_ok) begin
            data <= mem[addr[AW-1:0]];
          end else begin
            data  <= 16'h0000;
            fault <= 1'b1;
          end
          // step is registered, so raising it here makes it high during COMMIT.
          step  <= 1'b1;
          state <= COMMIT;
        end
        COMMIT: begin
          if (write && !addr_ok) begin
`ifdef MEM_RESP_MMIO_EN
            if (addr_io) begin
              io_out <= wdata;
            end else begin
              fault <= 1'b1;
            end
`else
            fault <= 1'b1;
`endif
          end
          state <= FETCH;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
